// File: rtl/des_pkg.sv
// des_pkg: shared DES constants, permutation tables and key-schedule helpers
package des_pkg;
  localparam int KEY_W = 64;
  localparam int RK_W = 48;
  localparam int HALF_W = 28;
  localparam int NROUNDS = 16;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [2*HALF_W-1:0] r;
    for (int i = 0; i < 2*HALF_W; i++) r[6'(2*HALF_W-1-i)] = k[6'(KEY_W-PC1[i])];
    return r;
  endfunction
  function automatic logic [HALF_W-1:0] rol(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return n == 2'd2 ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction
  function automatic logic [HALF_W-1:0] ror(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return n == 2'd2 ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: PC-2 compression permutation from the 56-bit C||D register to a 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd,
  output logic [RK_W-1:0]     round_key
);
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};
  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign round_key[RK_W-1-i] = cd[6'(2*HALF_W-PC2[i])];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES subkey generator emitting K1..K16 or K16..K1 per key
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             decrypt,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  round_key,
  output logic [3:0]       round_idx,
  output logic             last
);
  state_t state, state_n;
  logic [HALF_W-1:0] c, d, c_n, d_n;
  logic [3:0] idx, idx_n, idx_inc;
  logic dir, dir_n;
  logic [1:0] sh;
  logic [2*HALF_W-1:0] cd0;
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32], key_in[24], key_in[16], key_in[8], key_in[0]};
  assign cd0 = pc1(key_in);
  assign rk_valid = state == RUN;
  assign last = rk_valid && idx == 4'(NROUNDS-1);
  assign round_idx = idx;
  assign idx_inc = idx + 4'd1;
  assign sh = dir ? SHIFT[~idx] : SHIFT[idx_inc];
  des_pc2 u_pc2 (.cd({c, d}), .round_key(round_key));
  // State, C/D halves and the registered key_ready that tracks the upcoming IDLE state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      idx <= '0;
      dir <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      state <= state_n;
      c <= c_n;
      d <= d_n;
      idx <= idx_n;
      dir <= dir_n;
      key_ready <= state_n == IDLE;
    end
  // Key load with the first encrypt shift folded in, then one rotation per accepted subkey
  always_comb begin
    state_n = state;
    c_n = c;
    d_n = d;
    idx_n = idx;
    dir_n = dir;
    if (state == IDLE && key_valid && key_ready) begin
      state_n = RUN;
      dir_n = decrypt;
      idx_n = '0;
      c_n = decrypt ? cd0[2*HALF_W-1:HALF_W] : rol(cd0[2*HALF_W-1:HALF_W], SHIFT[0]);
      d_n = decrypt ? cd0[HALF_W-1:0] : rol(cd0[HALF_W-1:0], SHIFT[0]);
    end else if (state == RUN && rk_ready) begin
      state_n = last ? IDLE : RUN;
      idx_n = last ? '0 : idx_inc;
      c_n = last ? c : dir ? ror(c, sh) : rol(c, sh);
      d_n = last ? d : dir ? ror(d, sh) : rol(d, sh);
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed-vector bench for the DES key schedule
module tb_des_key_schedule;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, decrypt = 1'b0, rk_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic key_ready, rk_valid, last;
  logic [47:0] round_key;
  logic [3:0] round_idx;
  int checks = 0, failures = 0;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY_ZERO = 64'h0101010101010101;
  logic [47:0] kenc [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  typedef struct packed {
    logic [63:0] key;
    logic        dec;
    logic        zero;
    logic [47:0] first_k;
    logic [47:0] final_k;
  } vec_t;
  vec_t vecs [5];
  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .decrypt(decrypt), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .round_key(round_key), .round_idx(round_idx), .last(last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  function automatic logic [47:0] exp_rk(input logic dec, input logic zero, input int n);
    return zero ? 48'h0 : dec ? kenc[15-n] : kenc[n];
  endfunction
  task automatic run_key(input logic [63:0] k, input logic dec, input logic zero, input int pct,
                         input logic hold, output logic [47:0] first_k, output logic [47:0] final_k);
    int t = 0;
    int n = 0;
    first_k = 'x;
    final_k = 'x;
    while (!key_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("key_ready_wait", key_ready, 1);
    key_in = k;
    decrypt = dec;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = hold;
    key_in = ~k;
    decrypt = ~dec;
    chk("latency_rk_valid", rk_valid, 1);
    t = 0;
    while (n < 16 && t < 400) begin
      rk_ready = ($urandom_range(99) < pct);
      chk("rk_valid", rk_valid, 1);
      chk("key_ready_run", key_ready, 0);
      chk("round_idx", round_idx, n);
      chk("round_key", round_key, exp_rk(dec, zero, n));
      chk("last", last, n == 15);
      if (n == 0) first_k = round_key;
      if (n == 15) final_k = round_key;
      @(negedge clk);
      t++;
      if (rk_ready) n++;
    end
    rk_ready = 1'b0;
    key_valid = 1'b0;
    chk("handshakes", n, 16);
    chk("key_ready_after", key_ready, 1);
    chk("rk_valid_after", rk_valid, 0);
    chk("last_after", last, 0);
    chk("round_idx_after", round_idx, 0);
  endtask
  initial begin
    logic [47:0] f, l;
    int t;
    vecs[0] = '{KEY, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[1] = '{KEY, 1'b1, 1'b0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2] = '{KEY_ZERO, 1'b0, 1'b1, 48'h0, 48'h0};
    vecs[3] = '{KEY_PAR, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[4] = '{KEY_ZERO, 1'b1, 1'b1, 48'h0, 48'h0};
    #1;
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_round_key", round_key, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_round_idx", round_idx, 0);
    repeat (2) @(negedge clk);
    chk("rst_key_ready_held", key_ready, 0);
    rst_n = 1'b1;
    #1 chk("key_ready_before_edge", key_ready, 0);
    @(negedge clk);
    chk("key_ready_first_edge", key_ready, 1);
    for (int i = 0; i < 5; i++) begin
      run_key(vecs[i].key, vecs[i].dec, vecs[i].zero, 100, 1'b0, f, l);
      chk("vec_first", f, vecs[i].first_k);
      chk("vec_final", l, vecs[i].final_k);
    end
    run_key(KEY, 1'b0, 1'b0, 40, 1'b0, f, l);
    chk("bp_first", f, 48'h1B02EFFC7072);
    run_key(KEY, 1'b1, 1'b0, 40, 1'b1, f, l);
    chk("hold_final", l, 48'h1B02EFFC7072);
    @(negedge clk);
    chk("mid_key_ready", key_ready, 1);
    key_in = KEY;
    decrypt = 1'b0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready = 1'b1;
    t = 0;
    while (round_idx != 4'd7 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("mid_idx", round_idx, 7);
    chk("mid_round_key", round_key, kenc[7]);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rk_valid", rk_valid, 0);
    chk("async_last", last, 0);
    chk("async_key_ready", key_ready, 0);
    chk("async_round_idx", round_idx, 0);
    key_in = KEY;
    decrypt = 1'b1;
    key_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    key_valid = 1'b0;
    rk_ready = 1'b0;
    #1;
    chk("post_rst_key_ready", key_ready, 0);
    chk("post_rst_rk_valid", rk_valid, 0);
    run_key(KEY, 1'b1, 1'b0, 100, 1'b0, f, l);
    chk("fresh_dec_first", f, 48'hCB3D8B0E17F5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
